// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO TX byte FIFO and RX holding reg.
// Optional RX path enabled by defining MMIO_RX_EN.
module data_mem_responder #(
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] di,
  output logic [31:0] dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
`ifdef MMIO_RX_EN
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
`endif
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [29:0] A_TX = 30'h3C00_0000;
  localparam logic [29:0] A_ST = 30'h3C00_0001;
  localparam logic [29:0] A_RX = 30'h3C00_0002;

  logic [31:0]        r_ram [2**RAM_AW];
  logic [7:0]         r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  logic              w_is_ram;
  logic              w_is_tx;
  logic              w_is_st;
  logic              w_is_rx;
  logic              w_rd;
  logic              w_wr;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic              w_ovf_clr;
  logic              w_rx_full;
  logic [31:0]       w_rx_rd;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused   = ^addr[1:0];

  assign w_is_ram   = addr[31:28] == 4'h0;
  assign w_is_tx    = addr[31:2] == A_TX;
  assign w_is_st    = addr[31:2] == A_ST;
  assign w_is_rx    = addr[31:2] == A_RX;
  assign w_rd       = en & ~we;
  assign w_wr       = en & we;
  assign w_ram_idx  = addr[RAM_AW+1:2];

  assign w_full     = r_count == (FIFO_AW+1)'(DEPTH);
  assign w_empty    = r_count == '0;
  assign tx_valid   = ~w_empty;
  assign tx_data    = r_fifo[r_rptr];
  assign w_pop      = tx_valid & tx_ready;
  assign w_push_req = w_wr & w_is_tx;
  // A full FIFO still takes a push when the head leaves this same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_wr & w_is_st & di[3];
  assign overflow   = r_ovf;

`ifdef MMIO_RX_EN
  logic       r_rx_full;
  logic [7:0] r_rx_byte;
  logic       w_rx_cap;
  logic       w_rx_pop;

  assign rx_ready  = ~r_rx_full;
  assign w_rx_cap  = rx_valid & ~r_rx_full;
  assign w_rx_pop  = w_rd & w_is_rx & r_rx_full;
  assign w_rx_full = r_rx_full;
  assign w_rx_rd   = {24'h0, r_rx_full ? r_rx_byte : 8'h00};

  // RX holding register: capture when empty, cleared by an RXDATA read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= 8'h00;
    end else if (w_rx_cap) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end
`else
  assign w_rx_full = 1'b0;
  assign w_rx_rd   = 32'h0;
`endif

  assign w_status = {16'h0, 8'(r_count), 4'h0,
                     r_ovf, w_rx_full, w_empty, w_full};

  // Read-data select; all MMIO views are pre-update register state.
  always_comb begin
    w_rdata = 32'h0;
    unique case (1'b1)
      w_is_ram: w_rdata = r_ram[w_ram_idx];
      w_is_st:  w_rdata = w_status;
      w_is_rx:  w_rdata = w_rx_rd;
      default:  w_rdata = 32'h0;
    endcase
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr && w_is_ram) begin
      r_ram[w_ram_idx] <= di;
    end
  end

  // FIFO storage write; data is discarded logically via the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= di[7:0];
    end
  end

  // Registered read data, held on write and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 32'h0;
    end else if (w_rd) begin
      dout <= w_rdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared by STATUS write bit 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with a queue-based reference model.
// Works with or without MMIO_RX_EN defined.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] di = 32'h0;
  logic        tx_ready = 1'b0;
  logic [31:0] dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overflow;
`ifdef MMIO_RX_EN
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
`endif

  localparam logic [31:0] TXA = 32'hF000_0000;
  localparam logic [31:0] STA = 32'hF000_0004;
  localparam logic [31:0] RXA = 32'hF000_0008;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  acc_q [$];
  logic [7:0]  mq [$];
  logic [31:0] ram_m [int];
  logic        ovf_m = 1'b0;
  logic        rxf_m = 1'b0;
  logic [7:0]  rxb_m = 8'h0;
  logic        g_rxv = 1'b0;
  logic [7:0]  g_rxd = 8'h0;

  data_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .we       (we),
    .addr     (addr),
    .di       (di),
    .dout     (dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
`ifdef MMIO_RX_EN
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
`endif
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(logic [31:0] a);
    logic [31:0] s;
    int sz;
    sz = mq.size();
    s = 32'h0;
    if (a[31:28] == 4'h0) return ram_m[int'(a[13:2])];
    case ({a[31:2], 2'b00})
      STA: begin
        s[15:8] = 8'(sz);
        s[3] = ovf_m;
        s[2] = rxf_m;
        s[1] = (sz == 0);
        s[0] = (sz == 16);
        return s;
      end
      RXA:     return rxf_m ? {24'h0, rxb_m} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // One request cycle: drive, update the model, advance past the edge.
  task automatic issue(logic e, logic w, logic [31:0] a,
                       logic [31:0] d, logic tr);
    logic pop;
    logic cap;
    en = e;
    we = w;
    addr = a;
    di = d;
    tx_ready = tr;
`ifdef MMIO_RX_EN
    rx_valid = g_rxv;
    rx_data = g_rxd;
    cap = g_rxv && !rxf_m;
`else
    cap = 1'b0;
`endif
    pop = (mq.size() > 0) && tr;
    if (e && !w) begin
      exp_q.push_back(model_rd(a));
      if ({a[31:2], 2'b00} == RXA) rxf_m = 1'b0;
    end
    if (cap) begin
      rxf_m = 1'b1;
      rxb_m = g_rxd;
    end
    if (pop) void'(mq.pop_front());
    if (e && w) begin
      if (a[31:28] == 4'h0) begin
        ram_m[int'(a[13:2])] = d;
      end else if ({a[31:2], 2'b00} == TXA) begin
        if (mq.size() < 16) begin
          mq.push_back(d[7:0]);
          acc_q.push_back(d[7:0]);
        end else begin
          ovf_m = 1'b1;
        end
      end else if ({a[31:2], 2'b00} == STA && d[3]) begin
        ovf_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, logic tr);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 32'h0, 32'h0, tr);
  endtask

  // Read-data monitor: any read seen on the bus is checked one cycle later.
  always @(posedge clk) begin
    if (rst_n && en && !we) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dout: read with no expectation, got %08h", dout);
      end else begin
        chk("dout", dout, exp_q.pop_front());
      end
    end
  end

  // TX stream monitor: every handshake must emit the next accepted byte.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (acc_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_data: extra byte %02h expected none", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, acc_q.pop_front()});
      end
    end
  end

  initial begin
    int op;
    logic tr;
    logic [31:0] ra;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
`ifdef MMIO_RX_EN
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
`endif
    rst_n = 1'b1;
    idle(1, 1'b0);

    issue(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_4010, 32'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
    chk("dout_hold_on_write", dout, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    issue(1'b1, 1'b1, TXA, 32'h41, 1'b0);
    issue(1'b1, 1'b1, TXA, 32'h42, 1'b0);
    issue(1'b1, 1'b1, TXA, 32'h43, 1'b0);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);
    idle(4, 1'b1);
    chk("tx_drained", 32'(tx_valid), 32'h0);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      issue(1'b1, 1'b1, TXA, 32'h60 + 32'(i), 1'b0);
    end
    chk("ovf_set", 32'(overflow), 32'h1);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);
    issue(1'b1, 1'b1, STA, 32'h8, 1'b0);
    chk("ovf_clr", 32'(overflow), 32'h0);
    issue(1'b1, 1'b1, TXA, 32'hAA, 1'b1);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);
    chk("ovf_full_pushpop", 32'(overflow), 32'h0);
    idle(20, 1'b1);

    issue(1'b1, 1'b0, 32'hF000_0010, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0);
    issue(1'b1, 1'b0, TXA, 32'h0, 1'b0);

`ifdef MMIO_RX_EN
    g_rxv = 1'b1;
    g_rxd = 8'h5A;
    idle(1, 1'b0);
    g_rxv = 1'b0;
    chk("rx_ready_full", 32'(rx_ready), 32'h0);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);
    g_rxv = 1'b1;
    g_rxd = 8'h77;
    idle(1, 1'b0);
    g_rxv = 1'b0;
    issue(1'b1, 1'b0, RXA, 32'h0, 1'b0);
    chk("rx_ready_after_pop", 32'(rx_ready), 32'h1);
`endif
    issue(1'b1, 1'b0, RXA, 32'h0, 1'b0);
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b1, 32'(i) << 2, $urandom, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      tr = 1'($urandom_range(0, 1));
      ra = {4'h0, 14'($urandom), 12'($urandom_range(0, 7)), 2'b00};
      if (op <= 5) begin
        issue(1'b1, 1'b1, TXA | 32'($urandom_range(0, 3)), $urandom, tr);
      end else if (op == 6) begin
        issue(1'b1, 1'b0, STA, 32'h0, tr);
      end else if (op == 7) begin
        issue(1'b1, 1'b1, ra, $urandom, tr);
      end else if (op == 8) begin
        issue(1'b1, 1'b0, ra, 32'h0, tr);
      end else begin
        idle(1, tr);
      end
    end
    idle(20, 1'b1);
    chk("tx_all_emitted", 32'(acc_q.size()), 32'h0);
    chk("tx_valid_final", 32'(tx_valid), 32'h0);

    issue(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, 1'b1, TXA, 32'h30 + 32'(i), 1'b0);
    end
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    idle(1, 1'b0);
    chk("pre_rst_dout", dout, 32'hCAFE_F00D);
    chk("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
    en = 1'b1;
    we = 1'b0;
    addr = 32'h0000_0100;
    #2 rst_n = 1'b0;
    mq.delete();
    acc_q.delete();
    ovf_m = 1'b0;
    rxf_m = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_dout", dout, 32'h0);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(1'b1, 1'b0, STA, 32'h0, 1'b0);
    idle(2, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
